trail_reader: RTL and testbench

Input-side counterpart to the LED trail driver. Samples a WIDTH-bit thermometer bar from external pins, such as a looped-back LED bar or a bank of switches, and synchronizes and debounces it. Decodes the bar into a fill level, tracks whether it is rising or falling, and flags illegal codes and completed fill/drain cycles. Sits at the board I/O boundary and feeds status logic or a test harness in the `clk` domain.

---
 rtl/trail_reader.sv | 166 ++++++++++++++++
 tb/tb_trail_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_reader.sv
// trail_reader: samples, debounces and decodes a thermometer bar input.
// Define TRAIL_READER_SYNC_EN for a two-flop synchronizer on pins_in.
module trail_reader #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           pins_in,
    output logic [$clog2(WIDTH+1)-1:0] level,
    output logic                       dir_up,
    output logic                       is_full,
    output logic                       step,
    output logic                       skip,
    output logic                       code_err,
    output logic                       cycle_done
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = WIDTH + 1;

    typedef enum logic [1:0] {
        EMPTY,
        RISING,
        FULL,
        FALLING
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             acc_new;
    logic             seen_full;

`ifdef TRAIL_READER_SYNC_EN
    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pins_in;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= pins_in;
        end
    end
`endif

    // acc_new marks the cycle after a fresh code was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            acc_new <= 1'b0;
        end else begin
            acc_new <= 1'b0;
            if (sync_q != cand_q) begin
                cand_q <= sync_q;
                cnt_q  <= CW'(1);
            end else if (cnt_q != CW'(STABLE_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(STABLE_CYCLES - 1) &&
                    cand_q != acc_q) begin
                    acc_q   <= cand_q;
                    acc_new <= 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] code_w;
    logic [DW-1:0] code_inc;
    logic          legal;
    logic [LW-1:0] new_lvl;
    logic [DW-1:0] new_w;
    logic [DW-1:0] old_w;
    logic [DW-1:0] mag;
    logic          to_full;
    logic          to_empty;
    logic          going_up;

    // legal iff code+1 is a power of two (no carry overlap)
    always_comb begin
        code_w   = {1'b0, acc_q};
        code_inc = code_w + DW'(1);
        legal    = (code_w & code_inc) == '0;
        new_lvl  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_lvl = new_lvl + LW'(acc_q[i]);
        end
        new_w    = DW'(new_lvl);
        old_w    = DW'(level);
        mag      = (new_w > old_w) ? new_w - old_w
                                   : old_w - new_w;
        to_full  = new_lvl == LW'(WIDTH);
        to_empty = new_lvl == '0;
        going_up = (new_lvl > level) && !to_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            level      <= '0;
            dir_up     <= 1'b0;
            step       <= 1'b0;
            skip       <= 1'b0;
            code_err   <= 1'b0;
            cycle_done <= 1'b0;
            seen_full  <= 1'b0;
        end else begin
            step       <= 1'b0;
            skip       <= 1'b0;
            cycle_done <= 1'b0;
            if (acc_new) begin
                if (!legal) begin
                    code_err <= 1'b1;
                end else begin
                    code_err <= 1'b0;
                    if (new_lvl != level) begin
                        step  <= 1'b1;
                        skip  <= mag > DW'(1);
                        level <= new_lvl;
                        unique case (1'b1)
                            to_full: begin
                                state     <= FULL;
                                dir_up    <= 1'b1;
                                seen_full <= 1'b1;
                            end
                            to_empty: begin
                                state  <= EMPTY;
                                dir_up <= 1'b0;
                                if (seen_full) begin
                                    cycle_done <= 1'b1;
                                    seen_full  <= 1'b0;
                                end
                            end
                            going_up: begin
                                state  <= RISING;
                                dir_up <= 1'b1;
                            end
                            default: begin
                                state  <= FALLING;
                                dir_up <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign is_full = (state == FULL);

endmodule

// File: tb/tb_trail_reader.sv
// tb_trail_reader: directed bench with a run-length reference model.
// Checks trail_reader outputs every cycle plus literal expectations.
module tb_trail_reader;

    localparam int W   = 5;
    localparam int SC  = 4;
`ifdef TRAIL_READER_SYNC_EN
    localparam int S   = 2;
`else
    localparam int S   = 1;
`endif
    localparam int LAT = S + SC + 1;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [W-1:0] pins_in = '0;
    logic [2:0]   level;
    logic         dir_up;
    logic         is_full;
    logic         step;
    logic         skip;
    logic         code_err;
    logic         cycle_done;

    int checks   = 0;
    int failures = 0;

    trail_reader #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pins_in   (pins_in),
        .level     (level),
        .dir_up    (dir_up),
        .is_full   (is_full),
        .step      (step),
        .skip      (skip),
        .code_err  (code_err),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    // model: sync delay as history, debounce as a run length
    logic [W-1:0] hist[$];
    logic [W-1:0] m_d;
    logic [W-1:0] m_last;
    logic [W-1:0] m_acc;
    int           m_run;
    int           m_k;
    int           m_diff;
    bit           m_pend;
    int           m_level;
    bit           m_dir;
    bit           m_err;
    bit           m_step;
    bit           m_skip;
    bit           m_done;
    bit           m_seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_last  = '0;
            m_acc   = '0;
            m_run   = 0;
            m_pend  = 0;
            m_level = 0;
            m_dir   = 0;
            m_err   = 0;
            m_step  = 0;
            m_skip  = 0;
            m_done  = 0;
            m_seen  = 0;
        end else begin
            m_step = 0;
            m_skip = 0;
            m_done = 0;
            if (m_pend) begin
                m_pend = 0;
                m_k    = -1;
                for (int j = 0; j <= W; j++) begin
                    if (int'(m_acc) == (1 << j) - 1) m_k = j;
                end
                if (m_k < 0) begin
                    m_err = 1;
                end else begin
                    m_err = 0;
                    if (m_k != m_level) begin
                        m_diff = m_k - m_level;
                        if (m_diff < 0) m_diff = -m_diff;
                        m_step = 1;
                        m_skip = m_diff > 1;
                        if (m_k == W) begin
                            m_dir  = 1;
                            m_seen = 1;
                        end else if (m_k == 0) begin
                            m_dir = 0;
                            if (m_seen) begin
                                m_done = 1;
                                m_seen = 0;
                            end
                        end else begin
                            m_dir = m_k > m_level;
                        end
                        m_level = m_k;
                    end
                end
            end
            hist.push_back(pins_in);
            m_d = (hist.size() > S) ? hist[hist.size() - 1 - S] : '0;
            if (hist.size() > S + 1) void'(hist.pop_front());
            if (m_run > 0 && m_d == m_last) begin
                if (m_run <= SC) m_run = m_run + 1;
            end else begin
                m_run = 1;
            end
            m_last = m_d;
            if (m_run == SC && m_d != m_acc) begin
                m_acc  = m_d;
                m_pend = 1;
            end
        end
    end

    logic [8:0] dut_v;
    logic [8:0] mod_v;
    assign dut_v = {level, dir_up, is_full, step, skip,
                    code_err, cycle_done};

    always @(negedge clk) begin
        mod_v = {3'(m_level), m_dir, m_level == W, m_step,
                 m_skip, m_err, m_done};
        checks = checks + 1;
        if (dut_v !== mod_v) begin
            failures = failures + 1;
            $display("FAIL model t=%0t actual=%b required=%b",
                     $time, dut_v, mod_v);
        end
    end

    int n_step = 0;
    int n_skip = 0;
    int n_done = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (step === 1'b1) n_step = n_step + 1;
            if (skip === 1'b1) n_skip = n_skip + 1;
            if (cycle_done === 1'b1) n_done = n_done + 1;
            if (step === 1'b1 && skip === 1'b1) n_both = n_both + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        pins_in = v;
        repeat (n) @(negedge clk);
    endtask

    int b_step;
    int b_skip;
    int b_done;
    int b_both;

    task automatic base();
        b_step = n_step;
        b_skip = n_skip;
        b_done = n_done;
        b_both = n_both;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(dut_v), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_level", 32'(level), 0);
        base();

        pins_in = 5'b00001;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("lat_before", 32'(level), 0);
        @(posedge clk);
        #1;
        chk("lat_level", 32'(level), 1);
        chk("lat_step", 32'(step), 1);
        chk("lat_skip", 32'(skip), 0);
        chk("lat_dir", 32'(dir_up), 1);
        @(negedge clk);
        repeat (8) @(negedge clk);

        hold(5'b00001, 10);
        hold(5'b00011, 10);
        chk("walk_l2", 32'(level), 2);
        hold(5'b00111, 10);
        hold(5'b01111, 10);
        hold(5'b11111, 10);
        chk("walk_full_level", 32'(level), 5);
        chk("walk_is_full", 32'(is_full), 1);
        chk("walk_steps", 32'(n_step - b_step), 5);
        chk("walk_skips", 32'(n_skip - b_skip), 0);

        base();
        hold(5'b01111, 10);
        chk("down_dir", 32'(dir_up), 0);
        chk("down_l4", 32'(level), 4);
        chk("down_not_full", 32'(is_full), 0);
        hold(5'b00111, 10);
        hold(5'b00011, 10);
        hold(5'b00001, 10);
        chk("down_no_done", 32'(n_done - b_done), 0);
        hold(5'b00000, 10);
        chk("down_level0", 32'(level), 0);
        chk("down_done", 32'(n_done - b_done), 1);
        chk("down_steps", 32'(n_step - b_step), 5);

        hold(5'b00001, 10);
        base();
        hold(5'b00011, 3);
        hold(5'b00001, 10);
        chk("glitch_level", 32'(level), 1);
        chk("glitch_steps", 32'(n_step - b_step), 0);

        hold(5'b00101, 10);
        chk("illegal_err", 32'(code_err), 1);
        chk("illegal_level", 32'(level), 1);
        chk("illegal_steps", 32'(n_step - b_step), 0);
        base();
        hold(5'b00111, 10);
        chk("recover_err", 32'(code_err), 0);
        chk("recover_level", 32'(level), 3);
        chk("recover_both", 32'(n_both - b_both), 1);
        chk("recover_steps", 32'(n_step - b_step), 1);

        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'(dut_v), 0);
        pins_in = 5'b11111;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("rr_before", 32'(level), 0);
        @(posedge clk);
        #1;
        chk("rr_level", 32'(level), 5);
        chk("rr_step", 32'(step), 1);
        chk("rr_skip", 32'(skip), 1);
        chk("rr_full", 32'(is_full), 1);
        @(negedge clk);
        repeat (8) @(negedge clk);

        base();
        hold(5'b00000, 10);
        chk("drop_level", 32'(level), 0);
        chk("drop_skip", 32'(n_skip - b_skip), 1);
        chk("drop_done", 32'(n_done - b_done), 1);
        chk("drop_dir", 32'(dir_up), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
